nec_ir_tx: RTL and testbench

- NEC-protocol infrared transmitter. It is the sending end of the IR remote link that the robot's IR receive path decodes.
- Accepts an 8-bit address/command pair, or a repeat request, through a valid/ready handshake.
- Serialises the request as a standard NEC frame and drives a carrier-modulated LED output.
- Used by the handheld/base-station board and for loopback testing of the robot's IR receive path.

---
 rtl/nec_ir_pkg.sv | 50 +++++
 rtl/nec_carrier_gen.sv | 45 ++++
 rtl/nec_ir_tx.sv | 180 ++++++++++++++++++
 tb/tb_nec_ir_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/nec_ir_pkg.sv
// Shared types and timing constants for the NEC IR transmitter.
// Durations are in NEC units (562.5 us each).
package nec_ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_MARK,
        HDR_SPACE,
        REP_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } state_t;

    localparam int unsigned UNIT_CNT_W  = 5;
    localparam int unsigned FRAME_CNT_W = 8;
    localparam int unsigned BIT_IDX_W   = 5;
    localparam int unsigned WORD_W      = 32;

    localparam int unsigned HDR_MARK_U   = 16;
    localparam int unsigned HDR_SPACE_U  = 8;
    localparam int unsigned REP_SPACE_U  = 4;
    localparam int unsigned BIT_MARK_U   = 1;
    localparam int unsigned ZERO_SPACE_U = 1;
    localparam int unsigned ONE_SPACE_U  = 3;
    localparam int unsigned STOP_U       = 1;

    // Length in units of a timed state; 0 for untimed states (IDLE, GAP).
    function automatic logic [UNIT_CNT_W-1:0] state_units(input state_t s, input logic bit_val);
        logic [UNIT_CNT_W-1:0] u;
        u = '0;
        case (s)
            HDR_MARK:  u = UNIT_CNT_W'(HDR_MARK_U);
            HDR_SPACE: u = UNIT_CNT_W'(HDR_SPACE_U);
            REP_SPACE: u = UNIT_CNT_W'(REP_SPACE_U);
            BIT_MARK:  u = UNIT_CNT_W'(BIT_MARK_U);
            BIT_SPACE: u = bit_val ? UNIT_CNT_W'(ONE_SPACE_U) : UNIT_CNT_W'(ZERO_SPACE_U);
            STOP_MARK: u = UNIT_CNT_W'(STOP_U);
            default:   u = '0;
        endcase
        return u;
    endfunction

    // States during which the LED is driven (carrier on).
    function automatic logic is_mark(input state_t s);
        return (s == HDR_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
    endfunction

endpackage

// File: rtl/nec_carrier_gen.sv
// Carrier phase generator.
//   clk, rst_n : clock, async active-low reset
//   restart    : forces the phase to 0 for the coming cycle (mark entry)
//   en         : advances the phase for the coming cycle
//   carrier    : carrier level for the coming cycle (combinational, meant
//                to be registered by the caller alongside the envelope)
module nec_carrier_gen
    import nec_ir_pkg::*;
#(
    parameter int unsigned CARRIER_DIV  = 1316,
    parameter int unsigned CARRIER_HIGH = 438
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic en,
    output logic carrier
);

    localparam int unsigned CNT_W = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Phase of the next output cycle; wraps at CARRIER_DIV-1.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_W'(CARRIER_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign carrier = (cnt_d < CNT_W'(CARRIER_HIGH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: accepts an address/command pair or a repeat
// request over valid/ready and sends it as a carrier-modulated NEC frame.
//   clk, rst_n    : clock, async active-low reset
//   valid/ready   : request handshake, ready only while idle
//   address       : NEC address byte
//   command       : NEC command byte
//   repeat_code   : send a repeat frame instead of data
//   ir_tx         : modulated LED drive (polarity set by TX_ACTIVE_HIGH)
//   ir_env        : unmodulated envelope, 1 during marks
//   busy          : frame or inter-frame gap in progress
module nec_ir_tx
    import nec_ir_pkg::*;
#(
    parameter int unsigned UNIT_CLKS      = 28125,
    parameter int unsigned CARRIER_DIV    = 1316,
    parameter int unsigned CARRIER_HIGH   = 438,
    parameter int unsigned PERIOD_UNITS   = 192,
    parameter bit          TX_ACTIVE_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    output logic       ready,
    input  logic [7:0] address,
    input  logic [7:0] command,
    input  logic       repeat_code,
    output logic       ir_tx,
    output logic       ir_env,
    output logic       busy
);

    localparam int unsigned UNIT_CLK_W = $clog2(UNIT_CLKS);
    localparam logic        TX_IDLE    = !TX_ACTIVE_HIGH;

    state_t                  state_q, state_d;
    logic [UNIT_CLK_W-1:0]   clk_cnt_q, clk_cnt_d;
    logic [UNIT_CNT_W-1:0]   unit_cnt_q, unit_cnt_d;
    logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [BIT_IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0]       shift_q, shift_d;
    logic                    rep_q, rep_d;
    logic                    ready_q, busy_q, ir_env_q, ir_tx_q;

    logic [UNIT_CNT_W-1:0]   dur_c;
    logic                    unit_tick_c;
    logic                    last_unit_c;
    logic                    gap_done_c;
    logic                    mark_d;
    logic                    mark_entry_c;
    logic                    carrier;
    logic                    tx_on_c;

    // Next-state and counter logic.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        unit_cnt_d  = unit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rep_d       = rep_q;

        dur_c       = state_units(state_q, shift_q[0]);
        unit_tick_c = (clk_cnt_q == UNIT_CLK_W'(UNIT_CLKS - 1));
        last_unit_c = unit_tick_c && (unit_cnt_q == dur_c - UNIT_CNT_W'(1));
        // Leave GAP one clock early: the IDLE cycle in which the next request
        // is accepted completes the PERIOD_UNITS header-to-header spacing.
        gap_done_c  = (frame_cnt_q == FRAME_CNT_W'(PERIOD_UNITS - 1)) &&
                      (clk_cnt_q == UNIT_CLK_W'(UNIT_CLKS - 2));

        if (state_q != IDLE) begin
            clk_cnt_d = unit_tick_c ? '0 : clk_cnt_q + UNIT_CLK_W'(1);
            if (unit_tick_c) begin
                unit_cnt_d = last_unit_c ? '0 : unit_cnt_q + UNIT_CNT_W'(1);
                if (frame_cnt_q != FRAME_CNT_W'(PERIOD_UNITS)) begin
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d     = HDR_MARK;
                    shift_d     = {~command, command, ~address, address};
                    rep_d       = repeat_code;
                    clk_cnt_d   = '0;
                    unit_cnt_d  = '0;
                    frame_cnt_d = '0;
                    bit_idx_d   = '0;
                end
            end
            HDR_MARK: begin
                if (last_unit_c) state_d = rep_q ? REP_SPACE : HDR_SPACE;
            end
            HDR_SPACE: begin
                if (last_unit_c) begin
                    state_d   = BIT_MARK;
                    bit_idx_d = '0;
                end
            end
            REP_SPACE: begin
                if (last_unit_c) state_d = STOP_MARK;
            end
            BIT_MARK: begin
                if (last_unit_c) state_d = BIT_SPACE;
            end
            BIT_SPACE: begin
                if (last_unit_c) begin
                    shift_d   = {1'b0, shift_q[WORD_W-1:1]};
                    bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    state_d   = (bit_idx_q == BIT_IDX_W'(WORD_W - 1)) ? STOP_MARK : BIT_MARK;
                end
            end
            STOP_MARK: begin
                if (last_unit_c) state_d = GAP;
            end
            GAP: begin
                unit_cnt_d = '0;
                if (gap_done_c) begin
                    state_d     = IDLE;
                    clk_cnt_d   = '0;
                    frame_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Carrier restarts on every entry into a mark so each mark opens high.
    assign mark_d       = is_mark(state_d);
    assign mark_entry_c = mark_d && !is_mark(state_q);

    nec_carrier_gen #(
        .CARRIER_DIV  (CARRIER_DIV),
        .CARRIER_HIGH (CARRIER_HIGH)
    ) u_carrier (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (mark_entry_c),
        .en      (mark_d),
        .carrier (carrier)
    );

    assign tx_on_c = carrier & mark_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            unit_cnt_q  <= '0;
            frame_cnt_q <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rep_q       <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            ir_env_q    <= 1'b0;
            ir_tx_q     <= TX_IDLE;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            unit_cnt_q  <= unit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rep_q       <= rep_d;
            ready_q     <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            ir_env_q    <= mark_d;
            ir_tx_q     <= TX_ACTIVE_HIGH ? tx_on_c : ~tx_on_c;
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign ir_env = ir_env_q;
    assign ir_tx  = ir_tx_q;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Directed bench for nec_ir_tx with scaled timing (8-clock unit, 4-clock carrier).
module tb_nec_ir_tx;

    localparam int U    = 8;
    localparam int DIV  = 4;
    localparam int HIGH = 2;
    localparam int PER  = 192;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic [7:0] address;
    logic [7:0] command;
    logic       repeat_code;
    logic       ready, ir_tx, ir_env, busy;
    logic       ready_n, ir_tx_n, ir_env_n, busy_n;

    int n_checks = 0;
    int n_pass   = 0;
    int runs[$];
    int exp_q[$];
    int carr_err;
    int inv_err;

    always #5 clk = ~clk;

    nec_ir_tx #(.UNIT_CLKS(U), .CARRIER_DIV(DIV), .CARRIER_HIGH(HIGH),
                .PERIOD_UNITS(PER), .TX_ACTIVE_HIGH(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready),
        .address(address), .command(command), .repeat_code(repeat_code),
        .ir_tx(ir_tx), .ir_env(ir_env), .busy(busy));

    nec_ir_tx #(.UNIT_CLKS(U), .CARRIER_DIV(DIV), .CARRIER_HIGH(HIGH),
                .PERIOD_UNITS(PER), .TX_ACTIVE_HIGH(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready_n),
        .address(address), .command(command), .repeat_code(repeat_code),
        .ir_tx(ir_tx_n), .ir_env(ir_env_n), .busy(busy_n));

    // Expected envelope run lengths in clocks: mark, space, mark, ... , final gap
    // measured from header start up to the cycle ready reappears.
    task automatic build_expected(input logic [7:0] a, input logic [7:0] c, input logic rep);
        logic [31:0] w;
        int sum;
        exp_q.delete();
        exp_q.push_back(16 * U);
        if (rep) begin
            exp_q.push_back(4 * U);
            exp_q.push_back(U);
        end else begin
            w = {~c, c, ~a, a};
            exp_q.push_back(8 * U);
            for (int i = 0; i < 32; i++) begin
                exp_q.push_back(U);
                exp_q.push_back(w[i] ? 3 * U : U);
            end
            exp_q.push_back(U);
        end
        sum = 0;
        foreach (exp_q[i]) sum += exp_q[i];
        exp_q.push_back(PER * U - 1 - sum);
    endtask

    // Present a request so it is accepted on the next rising edge.
    task automatic send(input logic [7:0] a, input logic [7:0] c, input logic rep, input bit keep);
        @(negedge clk);
        address = a; command = c; repeat_code = rep; valid = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) valid = 1'b0;
    endtask

    // Capture envelope runs and carrier/polarity errors of one frame.
    // lead: negedges before the first mark; acc_edge: first edge (relative to
    // header start) on which a new request can be accepted.
    task automatic record_frame(output int lead, output int acc_edge);
        logic prev;
        int   run, phase;
        bit   started;
        logic exp_tx;
        runs.delete();
        carr_err = 0; inv_err = 0;
        lead = -1; acc_edge = -1;
        prev = 1'b0; run = 0; phase = 0; started = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (ir_tx_n !== ~ir_tx || ir_env_n !== ir_env || busy_n !== busy || ready_n !== ready)
                inv_err++;
            if (!started) begin
                if (ir_env !== 1'b1) continue;
                started = 1'b1;
                lead = n;
            end
            if (ready === 1'b1) begin
                runs.push_back(run);
                acc_edge = n - lead + 1;
                break;
            end
            if (ir_env !== prev) begin
                if (run > 0) runs.push_back(run);
                run = 0; phase = 0; prev = ir_env;
            end
            run++;
            exp_tx = ir_env && ((phase % DIV) < HIGH);
            phase++;
            if (ir_tx !== exp_tx) carr_err++;
        end
    endtask

    function automatic int first_run_mismatch();
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= runs.size() || runs[i] != exp_q[i]) return i;
        if (runs.size() != exp_q.size()) return exp_q.size();
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; address = '0; command = '0; repeat_code = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (ir_env !== 1'b0) $display("FAIL reset_env: got %b expected 0", ir_env); else n_pass++;
        n_checks++; if (ir_tx !== 1'b0) $display("FAIL reset_tx: got %b expected 0", ir_tx); else n_pass++;
        n_checks++; if (ir_tx_n !== 1'b1) $display("FAIL reset_tx_inv: got %b expected 1", ir_tx_n); else n_pass++;
    endtask

    task automatic test_data_frame();
        logic [7:0] va[2] = '{8'h00, 8'hA5};
        logic [7:0] vc[2] = '{8'h02, 8'h3C};
        int lead, acc, bad;
        for (int v = 0; v < 2; v++) begin
            build_expected(va[v], vc[v], 1'b0);
            send(va[v], vc[v], 1'b0, 1'b0);
            record_frame(lead, acc);
            bad = first_run_mismatch();
            n_checks++; if (lead !== 0) $display("FAIL data%0d_lead: got %0d expected 0", v, lead); else n_pass++;
            n_checks++; if (bad >= 0) $display("FAIL data%0d_runs idx %0d: got %0d expected %0d", v, bad,
                bad < runs.size() ? runs[bad] : -1, bad < exp_q.size() ? exp_q[bad] : -1); else n_pass++;
            n_checks++; if (acc !== PER * U) $display("FAIL data%0d_accept_edge: got %0d expected %0d", v, acc, PER * U); else n_pass++;
            n_checks++; if (carr_err !== 0) $display("FAIL data%0d_carrier: got %0d errors expected 0", v, carr_err); else n_pass++;
            n_checks++; if (inv_err !== 0) $display("FAIL data%0d_inverted: got %0d errors expected 0", v, inv_err); else n_pass++;
        end
    endtask

    task automatic test_repeat();
        int lead, acc, bad;
        build_expected(8'h00, 8'h00, 1'b1);
        send(8'hFF, 8'hFF, 1'b1, 1'b0);
        record_frame(lead, acc);
        bad = first_run_mismatch();
        n_checks++; if (lead !== 0) $display("FAIL rep_lead: got %0d expected 0", lead); else n_pass++;
        n_checks++; if (bad >= 0) $display("FAIL rep_runs idx %0d: got %0d expected %0d", bad,
            bad < runs.size() ? runs[bad] : -1, bad < exp_q.size() ? exp_q[bad] : -1); else n_pass++;
        n_checks++; if (acc !== PER * U) $display("FAIL rep_accept_edge: got %0d expected %0d", acc, PER * U); else n_pass++;
        n_checks++; if (carr_err !== 0) $display("FAIL rep_carrier: got %0d errors expected 0", carr_err); else n_pass++;
        n_checks++; if (inv_err !== 0) $display("FAIL rep_inverted: got %0d errors expected 0", inv_err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] cmds[2] = '{8'hA0, 8'h5B};
        int lead, acc, bad;
        send(8'h11, cmds[0], 1'b0, 1'b1);
        command = cmds[1];
        for (int f = 0; f < 2; f++) begin
            build_expected(8'h11, cmds[f], 1'b0);
            record_frame(lead, acc);
            bad = first_run_mismatch();
            n_checks++; if (lead !== 0) $display("FAIL b2b%0d_header_start: got %0d expected 0", f, lead); else n_pass++;
            n_checks++; if (bad >= 0) $display("FAIL b2b%0d_runs idx %0d: got %0d expected %0d", f, bad,
                bad < runs.size() ? runs[bad] : -1, bad < exp_q.size() ? exp_q[bad] : -1); else n_pass++;
            n_checks++; if (acc !== PER * U) $display("FAIL b2b%0d_accept_edge: got %0d expected %0d", f, acc, PER * U); else n_pass++;
            n_checks++; if (carr_err !== 0) $display("FAIL b2b%0d_carrier: got %0d errors expected 0", f, carr_err); else n_pass++;
            n_checks++; if (inv_err !== 0) $display("FAIL b2b%0d_inverted: got %0d errors expected 0", f, inv_err); else n_pass++;
        end
        valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int lead, acc, bad;
        send(8'h00, 8'h02, 1'b0, 1'b0);
        // Negedge 204 after header start lies in the first bit space.
        repeat (205) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b expected 1", busy); else n_pass++;
        n_checks++; if (ir_env !== 1'b0) $display("FAIL mid_space_env: got %b expected 0", ir_env); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (ir_env !== 1'b0) $display("FAIL rst_env: got %b expected 0", ir_env); else n_pass++;
        n_checks++; if (ir_tx !== 1'b0) $display("FAIL rst_tx: got %b expected 0", ir_tx); else n_pass++;
        n_checks++; if (ir_tx_n !== 1'b1) $display("FAIL rst_tx_inv: got %b expected 1", ir_tx_n); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        build_expected(8'h00, 8'h02, 1'b0);
        send(8'h00, 8'h02, 1'b0, 1'b0);
        record_frame(lead, acc);
        bad = first_run_mismatch();
        n_checks++; if (lead !== 0) $display("FAIL post_rst_lead: got %0d expected 0", lead); else n_pass++;
        n_checks++; if (bad >= 0) $display("FAIL post_rst_runs idx %0d: got %0d expected %0d", bad,
            bad < runs.size() ? runs[bad] : -1, bad < exp_q.size() ? exp_q[bad] : -1); else n_pass++;
        n_checks++; if (acc !== PER * U) $display("FAIL post_rst_accept_edge: got %0d expected %0d", acc, PER * U); else n_pass++;
        n_checks++; if (carr_err !== 0) $display("FAIL post_rst_carrier: got %0d errors expected 0", carr_err); else n_pass++;
        n_checks++; if (inv_err !== 0) $display("FAIL post_rst_inverted: got %0d errors expected 0", inv_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_data_frame();
        test_repeat();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
